// File: rtl/cpu_fwd_pkg.sv
// rtl/cpu_fwd_pkg.sv - entry type, stage indices and result-capture helper for the forwarding scoreboard
package cpu_fwd_pkg;

   // Widest configuration the shared entry type can carry.
   localparam int FWD_MAX_XLEN = 32;
   localparam int FWD_MAX_AW   = 5;

   localparam int STG_E      = 0;
   localparam int STG_M      = 1;
   localparam int STG_W      = 2;
   localparam int FWD_SRC_RF = 0;

   typedef struct packed {
      logic                    valid;
      logic [FWD_MAX_AW-1:0]   addr;
      logic                    ready;
      logic [FWD_MAX_XLEN-1:0] data;
   } fwd_entry_t;

   // A result only lands in a live entry whose value is still outstanding.
   function automatic fwd_entry_t fwd_capture(input fwd_entry_t             e,
                                              input logic                   res_v,
                                              input logic [FWD_MAX_XLEN-1:0] res_d);
      fwd_entry_t r;
      r = e;
      if (e.valid && !e.ready && res_v) begin
         r.ready = 1'b1;
         r.data  = res_d;
      end
      return r;
   endfunction

endpackage

// File: rtl/fwd_lookup.sv
// rtl/fwd_lookup.sv - per-port youngest-match search, operand mux and stall request
module fwd_lookup
   import cpu_fwd_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int AW    = 5,
   parameter int DEPTH = 3,
   parameter int SW    = 2
) (
   input  logic [DEPTH-1:0]           ent_valid,
   input  logic [DEPTH-1:0]           ent_ready,
   input  logic [DEPTH-1:0][AW-1:0]   ent_addr,
   input  logic [DEPTH-1:0][XLEN-1:0] ent_data,
   input  logic [AW-1:0]              rd_addr,
   input  logic [XLEN-1:0]            rf_data,
   output logic [XLEN-1:0]            rd_data,
   output logic [SW-1:0]              fwd_src,
   output logic                       stall_req
);

   logic            hit;
   logic            hit_ready;
   logic [XLEN-1:0] hit_data;
   logic [SW-1:0]   hit_src;

   // Oldest-to-youngest scan: a later (younger) match overrides an earlier one.
   always_comb begin
      hit       = 1'b0;
      hit_ready = 1'b0;
      hit_data  = '0;
      hit_src   = SW'(FWD_SRC_RF);
      for (int s = DEPTH - 1; s >= 0; s--) begin
         if (ent_valid[s] && (ent_addr[s] == rd_addr) && (rd_addr != '0)) begin
            hit       = 1'b1;
            hit_ready = ent_ready[s];
            hit_data  = ent_data[s];
            hit_src   = SW'(s + 1);
         end
      end
   end

   always_comb begin
      rd_data   = (hit && hit_ready) ? hit_data : rf_data;
      fwd_src   = hit_src;
      stall_req = hit && !hit_ready;
   end

endmodule

// File: rtl/fwd_scoreboard.sv
// rtl/fwd_scoreboard.sv - pending-write scoreboard with operand forwarding and decode stall
module fwd_scoreboard
   import cpu_fwd_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int NREG  = 32,
   parameter int DEPTH = 3,
   parameter int NPORT = 2,
   parameter int AW    = $clog2(NREG),
   parameter int SW    = $clog2(DEPTH + 1)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   hold,
   input  logic                   flush,
   input  logic                   iss_valid,
   input  logic [AW-1:0]          iss_addr,
   input  logic                   iss_ready,
   input  logic [XLEN-1:0]        iss_data,
   input  logic [DEPTH-1:0]       res_valid,
   input  logic [DEPTH*XLEN-1:0]  res_data,
   input  logic [NPORT-1:0]       rd_en,
   input  logic [NPORT*AW-1:0]    rd_addr,
   input  logic [NPORT*XLEN-1:0]  rf_data,
   output logic [NPORT*XLEN-1:0]  rd_data,
   output logic [NPORT*SW-1:0]    fwd_src,
   output logic                   stall,
   output logic [31:0]            stall_cnt
);

   fwd_entry_t [DEPTH-1:0]     ent_q;
   fwd_entry_t [DEPTH-1:0]     ent_d;
   fwd_entry_t [DEPTH-1:0]     ent_cap;
   fwd_entry_t                 iss_ent;
   logic                       iss_load;
   logic [31:0]                stall_cnt_q;
   logic [31:0]                stall_cnt_d;
   logic [NPORT-1:0]           stall_req;
   logic [DEPTH-1:0]           ent_valid;
   logic [DEPTH-1:0]           ent_ready;
   logic [DEPTH-1:0][AW-1:0]   ent_addr;
   logic [DEPTH-1:0][XLEN-1:0] ent_data;

   always_comb begin
      for (int s = 0; s < DEPTH; s++) begin
         ent_cap[s]   = fwd_capture(ent_q[s], res_valid[s],
                                    FWD_MAX_XLEN'(res_data[s*XLEN +: XLEN]));
         ent_valid[s] = ent_q[s].valid;
         ent_ready[s] = ent_q[s].ready;
         ent_addr[s]  = ent_q[s].addr[AW-1:0];
         ent_data[s]  = ent_q[s].data[XLEN-1:0];
      end
   end

   // r0 writes never create a live entry; a stalled or flushed issue becomes a bubble.
   always_comb begin
      iss_load = iss_valid && (iss_addr != '0) && !stall && !flush;
      iss_ent  = '0;
      if (iss_load) begin
         iss_ent.valid = 1'b1;
         iss_ent.addr  = FWD_MAX_AW'(iss_addr);
         iss_ent.ready = iss_ready;
         iss_ent.data  = FWD_MAX_XLEN'(iss_data);
      end
   end

   always_comb begin
      ent_d = ent_cap;
      if (!hold) begin
         ent_d[0] = iss_ent;
         for (int s = 1; s < DEPTH; s++) begin
            ent_d[s] = ent_cap[s-1];
         end
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ent_q       <= '0;
         stall_cnt_q <= '0;
      end else begin
         ent_q       <= ent_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   for (genvar p = 0; p < NPORT; p++) begin : g_port
      fwd_lookup #(
         .XLEN  (XLEN),
         .AW    (AW),
         .DEPTH (DEPTH),
         .SW    (SW)
      ) u_lookup (
         .ent_valid (ent_valid),
         .ent_ready (ent_ready),
         .ent_addr  (ent_addr),
         .ent_data  (ent_data),
         .rd_addr   (rd_addr[p*AW +: AW]),
         .rf_data   (rf_data[p*XLEN +: XLEN]),
         .rd_data   (rd_data[p*XLEN +: XLEN]),
         .fwd_src   (fwd_src[p*SW +: SW]),
         .stall_req (stall_req[p])
      );
   end

   assign stall     = |(rd_en & stall_req);
   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb/tb_fwd_scoreboard.sv - directed and randomized checks of the forwarding scoreboard
module tb_fwd_scoreboard;
   import cpu_fwd_pkg::*;

   logic        clk;
   logic        reset;
   logic        hold;
   logic        flush;
   logic        iss_valid;
   logic [4:0]  iss_addr;
   logic        iss_ready;
   logic [31:0] iss_data;
   logic [2:0]  res_valid;
   logic [95:0] res_data;
   logic [1:0]  rd_en;
   logic [9:0]  rd_addr;
   logic [63:0] rf_data;
   logic [63:0] rd_data;
   logic [3:0]  fwd_src;
   logic        stall;
   logic [31:0] stall_cnt;

   int total = 0;
   int bad   = 0;

   fwd_scoreboard dut (
      .clk       (clk),
      .reset     (reset),
      .hold      (hold),
      .flush     (flush),
      .iss_valid (iss_valid),
      .iss_addr  (iss_addr),
      .iss_ready (iss_ready),
      .iss_data  (iss_data),
      .res_valid (res_valid),
      .res_data  (res_data),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .rf_data   (rf_data),
      .rd_data   (rd_data),
      .fwd_src   (fwd_src),
      .stall     (stall),
      .stall_cnt (stall_cnt)
   );

   always #5 clk = ~clk;

   // Reference: in-flight writers ordered by age, index 0 = just issued.
   typedef struct {
      bit          v;
      bit [4:0]    a;
      bit          r;
      bit [31:0]   d;
   } inflight_t;

   inflight_t   pipe[$];
   longint      exp_cnt;

   function automatic void model_reset();
      inflight_t b;
      b = '{v: 1'b0, a: 5'd0, r: 1'b0, d: 32'd0};
      pipe.delete();
      for (int k = 0; k < 3; k++) pipe.push_back(b);
      exp_cnt = 0;
   endfunction

   function automatic void model_lookup(input logic [4:0] a, input logic [31:0] rf,
                                        output logic [31:0] d, output logic [1:0] src,
                                        output bit req);
      d   = rf;
      src = 2'd0;
      req = 1'b0;
      if (a != 5'd0) begin
         for (int k = 0; k < 3; k++) begin
            if (pipe[k].v && pipe[k].a == a) begin
               src = 2'(k + 1);
               if (pipe[k].r) d = pipe[k].d;
               else           req = 1'b1;
               break;
            end
         end
      end
   endfunction

   function automatic void model_clock(input bit stall_e);
      inflight_t n;
      for (int k = 0; k < 3; k++) begin
         if (pipe[k].v && !pipe[k].r && res_valid[k]) begin
            pipe[k].r = 1'b1;
            pipe[k].d = res_data[k*32 +: 32];
         end
      end
      if (!hold) begin
         n = '{v: 1'b0, a: 5'd0, r: 1'b0, d: 32'd0};
         if (iss_valid && iss_addr != 5'd0 && !stall_e && !flush)
            n = '{v: 1'b1, a: iss_addr, r: iss_ready, d: iss_data};
         pipe.push_front(n);
         void'(pipe.pop_back());
      end
      if (stall_e && exp_cnt < 64'hFFFF_FFFF) exp_cnt++;
   endfunction

   task automatic set_idle();
      hold      = 1'b0;
      flush     = 1'b0;
      iss_valid = 1'b0;
      iss_addr  = 5'd0;
      iss_ready = 1'b0;
      iss_data  = 32'd0;
      res_valid = 3'd0;
      res_data  = 96'd0;
      rd_en     = 2'd0;
      rd_addr   = 10'd0;
      rf_data   = {32'hAAAA_0001, 32'hAAAA_0000};
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      set_idle();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      do_reset();
      rd_en   = 2'b11;
      rd_addr = {5'd7, 5'd3};
      rf_data = {$urandom, $urandom};
      #1;
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0d want=0", stall); end
      total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", stall_cnt); end
      total++; if (fwd_src !== 4'd0) begin bad++; $display("FAIL reset_src got=%0h want=0", fwd_src); end
      total++; if (rd_data !== rf_data) begin bad++; $display("FAIL reset_data got=%h want=%h", rd_data, rf_data); end
   endtask

   task automatic test_alu_fwd();
      do_reset();
      iss_valid = 1'b1; iss_addr = 5'd3; iss_ready = 1'b0;
      tick();
      iss_valid = 1'b0;
      res_valid[STG_E] = 1'b1; res_data[31:0] = 32'h0000_0005;
      rd_en = 2'b01; rd_addr[4:0] = 5'd3;
      #1;
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL alu_stall got=%0d want=1", stall); end
      total++; if (fwd_src[1:0] !== 2'd1) begin bad++; $display("FAIL alu_src0 got=%0d want=1", fwd_src[1:0]); end
      total++; if (rd_data[31:0] !== rf_data[31:0]) begin bad++; $display("FAIL alu_rf got=%h want=%h", rd_data[31:0], rf_data[31:0]); end
      tick();
      res_valid = 3'd0;
      #1;
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL alu_nostall got=%0d want=0", stall); end
      total++; if (rd_data[31:0] !== 32'h5) begin bad++; $display("FAIL alu_data got=%h want=5", rd_data[31:0]); end
      total++; if (fwd_src[1:0] !== 2'd2) begin bad++; $display("FAIL alu_src1 got=%0d want=2", fwd_src[1:0]); end
   endtask

   task automatic test_load_fwd();
      do_reset();
      iss_valid = 1'b1; iss_addr = 5'd4; iss_ready = 1'b0;
      tick();
      iss_valid = 1'b0;
      rd_en = 2'b10; rd_addr[9:5] = 5'd4;
      #1;
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL load_stall1 got=%0d want=1", stall); end
      tick();
      res_valid[STG_M] = 1'b1; res_data[63:32] = 32'hDEAD_BEEF;
      #1;
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL load_stall2 got=%0d want=1", stall); end
      tick();
      res_valid = 3'd0;
      #1;
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL load_nostall got=%0d want=0", stall); end
      total++; if (rd_data[63:32] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL load_data got=%h want=deadbeef", rd_data[63:32]); end
      total++; if (fwd_src[3:2] !== 2'd3) begin bad++; $display("FAIL load_src got=%0d want=3", fwd_src[3:2]); end
      total++; if (stall_cnt !== 32'd2) begin bad++; $display("FAIL load_cnt got=%0d want=2", stall_cnt); end
   endtask

   task automatic test_jal();
      do_reset();
      iss_valid = 1'b1; iss_addr = 5'd31; iss_ready = 1'b1; iss_data = 32'h0040_0008;
      tick();
      iss_valid = 1'b0;
      rd_en = 2'b01; rd_addr[4:0] = 5'd31;
      #1;
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL jal_stall got=%0d want=0", stall); end
      total++; if (rd_data[31:0] !== 32'h0040_0008) begin bad++; $display("FAIL jal_data got=%h want=00400008", rd_data[31:0]); end
      total++; if (fwd_src[1:0] !== 2'd1) begin bad++; $display("FAIL jal_src got=%0d want=1", fwd_src[1:0]); end
   endtask

   task automatic test_priority();
      for (int young_ready = 1; young_ready >= 0; young_ready--) begin
         do_reset();
         iss_valid = 1'b1; iss_addr = 5'd5; iss_ready = 1'b1; iss_data = 32'h11;
         tick();
         iss_valid = 1'b0;
         tick();
         iss_valid = 1'b1; iss_ready = 1'(young_ready); iss_data = 32'h22;
         tick();
         iss_valid = 1'b0;
         rd_en = 2'b10; rd_addr[9:5] = 5'd5;
         #1;
         total++; if (fwd_src[3:2] !== 2'd1) begin bad++; $display("FAIL prio_src got=%0d want=1", fwd_src[3:2]); end
         if (young_ready == 1) begin
            total++; if (rd_data[63:32] !== 32'h22) begin bad++; $display("FAIL prio_data got=%h want=22", rd_data[63:32]); end
         end else begin
            total++; if (stall !== 1'b1) begin bad++; $display("FAIL prio_stall got=%0d want=1", stall); end
         end
      end
   endtask

   task automatic test_r0_and_rden();
      do_reset();
      iss_valid = 1'b1; iss_addr = 5'd0; iss_ready = 1'b1; iss_data = 32'h99;
      tick();
      iss_valid = 1'b0;
      rd_en = 2'b01; rd_addr[4:0] = 5'd0; rf_data[31:0] = 32'h1234;
      #1;
      total++; if (fwd_src[1:0] !== 2'd0) begin bad++; $display("FAIL r0_src got=%0d want=0", fwd_src[1:0]); end
      total++; if (rd_data[31:0] !== 32'h1234) begin bad++; $display("FAIL r0_data got=%h want=1234", rd_data[31:0]); end
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL r0_stall got=%0d want=0", stall); end
      iss_valid = 1'b1; iss_addr = 5'd7; iss_ready = 1'b0;
      tick();
      iss_valid = 1'b0;
      rd_en = 2'b00; rd_addr[4:0] = 5'd7;
      #1;
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL rden_stall got=%0d want=0", stall); end
      total++; if (fwd_src[1:0] !== 2'd1) begin bad++; $display("FAIL rden_src got=%0d want=1", fwd_src[1:0]); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      iss_valid = 1'b1; iss_addr = 5'd9; iss_ready = 1'b0;
      tick();
      iss_valid = 1'b0;
      hold = 1'b1; rd_en = 2'b11; rd_addr = {5'd9, 5'd9};
      for (int i = 0; i < 7; i++) tick();
      total++; if (stall_cnt !== 32'd7) begin bad++; $display("FAIL mid_cnt7 got=%0d want=7", stall_cnt); end
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL mid_stall1 got=%0d want=1", stall); end
      reset = 1'b1;
      #1;
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL mid_stall0 got=%0d want=0", stall); end
      total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL mid_cnt0 got=%0d want=0", stall_cnt); end
      total++; if (fwd_src !== 4'd0) begin bad++; $display("FAIL mid_src got=%0h want=0", fwd_src); end
      reset = 1'b0;
      set_idle();
      tick();
   endtask

   task automatic test_hold();
      do_reset();
      iss_valid = 1'b1; iss_addr = 5'd10; iss_ready = 1'b0;
      tick();
      iss_valid = 1'b0;
      tick();
      hold = 1'b1; rd_en = 2'b11; rd_addr = {5'd11, 5'd10};
      iss_valid = 1'b1; iss_addr = 5'd11; iss_ready = 1'b1; iss_data = 32'h77;
      for (int i = 0; i < 3; i++) begin
         res_valid = (i == 1) ? 3'b010 : 3'b000;
         res_data[63:32] = 32'h0000_CAFE;
         #1;
         total++; if (fwd_src[1:0] !== 2'd2) begin bad++; $display("FAIL hold_src%0d got=%0d want=2", i, fwd_src[1:0]); end
         total++; if (stall !== (i < 2)) begin bad++; $display("FAIL hold_stall%0d got=%0d want=%0d", i, stall, (i < 2)); end
         total++; if (fwd_src[3:2] !== 2'd0) begin bad++; $display("FAIL hold_iss%0d got=%0d want=0", i, fwd_src[3:2]); end
         tick();
      end
      res_valid = 3'd0;
      #1;
      total++; if (rd_data[31:0] !== 32'h0000_CAFE) begin bad++; $display("FAIL hold_data got=%h want=cafe", rd_data[31:0]); end
      hold = 1'b0; iss_valid = 1'b0;
      tick();
      total++; if (fwd_src[1:0] !== 2'd3) begin bad++; $display("FAIL hold_release got=%0d want=3", fwd_src[1:0]); end
   endtask

   task automatic test_random();
      logic [31:0] ed;
      logic [1:0]  es;
      bit          er;
      bit          exp_stall;
      do_reset();
      for (int cyc = 0; cyc < 400; cyc++) begin
         hold      = ($urandom_range(7) == 0);
         flush     = ($urandom_range(7) == 0);
         iss_valid = $urandom_range(1);
         iss_addr  = 5'($urandom_range(7));
         iss_ready = $urandom_range(1);
         iss_data  = $urandom;
         res_valid = 3'($urandom);
         res_data  = {$urandom, $urandom, $urandom};
         rd_en     = 2'($urandom);
         rd_addr   = {5'($urandom_range(7)), 5'($urandom_range(7))};
         rf_data   = {$urandom, $urandom};
         #1;
         exp_stall = 1'b0;
         for (int p = 0; p < 2; p++) begin
            model_lookup(rd_addr[p*5 +: 5], rf_data[p*32 +: 32], ed, es, er);
            if (er && rd_en[p]) exp_stall = 1'b1;
            total++; if (rd_data[p*32 +: 32] !== ed) begin bad++; $display("FAIL rnd_data c%0d p%0d got=%h want=%h", cyc, p, rd_data[p*32 +: 32], ed); end
            total++; if (fwd_src[p*2 +: 2] !== es) begin bad++; $display("FAIL rnd_src c%0d p%0d got=%0d want=%0d", cyc, p, fwd_src[p*2 +: 2], es); end
         end
         total++; if (stall !== exp_stall) begin bad++; $display("FAIL rnd_stall c%0d got=%0d want=%0d", cyc, stall, exp_stall); end
         total++; if (stall_cnt !== 32'(exp_cnt)) begin bad++; $display("FAIL rnd_cnt c%0d got=%0d want=%0d", cyc, stall_cnt, exp_cnt); end
         model_clock(exp_stall);
         tick();
      end
   endtask

   initial begin
      clk   = 1'b0;
      reset = 1'b1;
      set_idle();
      model_reset();
      test_reset();
      test_alu_fwd();
      test_load_fwd();
      test_jal();
      test_priority();
      test_r0_and_rden();
      test_reset_mid();
      test_hold();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fwd_scoreboard.md
# fwd_scoreboard

Parametrised operand-forwarding and hazard unit for the pipelined MIPS core. It generalises the fixed three-way decode-stage operand select to NPORT read ports and DEPTH in-flight producer stages. It holds a registered scoreboard of pending register writes (destination, ready flag, value) that advances with the pipeline. Each cycle it returns either the youngest matching forwarded value or the register-file value, and raises `stall` when a needed value is not yet produced. It sits beside the decode stage, feeding branch compare operands and the D/E operand registers.

## Interface
Parameters:
- XLEN, 32, data width
- NREG, 32, architectural registers; AW = $clog2(NREG)
- DEPTH, 3, tracked stages after decode (0=E, 1=M, 2=W)
- NPORT, 2, read ports
- SW = $clog2(DEPTH+1), source-select width

Ports (clock and reset first):
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high; clears all state
- hold  in  1  global freeze; entries keep position
- flush  in  1  load bubble into stage 0 this cycle
- iss_valid  in  1  decode issues a register-writing instruction
- iss_addr  in  AW  destination register
- iss_ready  in  1  value known at issue (e.g. jal pc+8)
- iss_data  in  XLEN  value when iss_ready
- res_valid  in  DEPTH  stage s produced its entry's result this cycle
- res_data  in  DEPTH*XLEN  result per stage, stage s at [s*XLEN +: XLEN]
- rd_en  in  NPORT  port p actually consumes its operand
- rd_addr  in  NPORT*AW  source registers
- rf_data  in  NPORT*XLEN  register-file read data
- rd_data  out  NPORT*XLEN  resolved operands
- fwd_src  out  NPORT*SW  0 = register file, s+1 = stage s
- stall  out  1  hazard; decode must hold
- stall_cnt  out  32  saturating count of stalled cycles

## Operation
- Entry = {valid, addr, ready, data}, DEPTH entries, registered.
- Issue: iss_valid with iss_addr != 0 creates entry {1, iss_addr, iss_ready, iss_data}. iss_addr == 0 creates an invalid entry.
- Stage 0 loads a bubble (valid=0) when stall, flush or !iss_valid. Otherwise it loads the issued entry.
- Advance (hold=0): entry[s+1] <= entry[s] with ready |= res_valid[s], and data <= res_data[s] if res_valid[s] and the entry is not already ready. The entry leaving stage DEPTH-1 is dropped.
- Hold (hold=1): no shift. entry[s] captures res_valid[s]/res_data[s] in place. Issue and flush are ignored. stall is still computed.
- res_valid[s] is ignored for an invalid or already-ready entry.
- Lookup per port: search stages 0..DEPTH-1 for a valid entry with addr == rd_addr[p]. The lowest index (youngest) wins.
  - Match and ready: rd_data = entry data, fwd_src = s+1.
  - Match and not ready: rd_data = rf_data, fwd_src = s+1, and this port requests a stall.
  - No match, or rd_addr == 0: rd_data = rf_data, fwd_src = 0.
- stall = OR over p of (rd_en[p] & port p requests a stall). Combinational from registered entries and inputs.
- Forwarding uses stored values only. A result produced in stage s is forwardable from stage s+1 on the next cycle.
- stall_cnt increments on every clk with stall=1 and saturates at 0xFFFFFFFF.

## Timing
- Reset (async assert, sync-released use): all entries invalid, stall_cnt=0. Outputs are then stall=0, fwd_src=0 and rd_data=rf_data.
- Reset mid-operation drops all pending entries immediately. No stall persists.
- Lookup-to-output is zero cycles (combinational). The scoreboard updates on posedge clk.
- ALU producer (result at end of E) feeding a D-stage consumer in the next cycle: 1 stall cycle. Load (result at end of M): 2 stall cycles.
- Simultaneous stall and iss_valid: stage 0 gets a bubble and the issue is dropped; decode re-presents it.
- Simultaneous flush and stall: bubble (same outcome).

## Structure
- Package cpu_fwd_pkg: fwd_entry_t struct, stage index constants (STG_E, STG_M, STG_W), FWD_SRC_RF = 0.
- Sub-module fwd_lookup: one instance per port, doing the priority search, the ready/stall decision and the mux. The top holds the entry shift register, issue/capture logic, the stall OR and stall_cnt.

## Test plan
- Issue r3 (iss_ready=0) at cycle 0; res_valid[0]=1 with 0x00000005 at cycle 1; read r3 with rd_en=1 at cycle 1 -> stall=1, fwd_src=1. At cycle 2 -> stall=0, rd_data=0x5, fwd_src=2.
- Load r4, result via res_valid[1]=0xDEADBEEF; consumer reads r4 the next cycle -> stall for 2 cycles, then rd_data=0xDEADBEEF with fwd_src=3, and stall_cnt=2.
- jal: issue r31 with iss_ready=1, iss_data=0x00400008; read r31 the next cycle -> no stall, rd_data=0x00400008, fwd_src=1.
- r5 in stage 2 (ready, 0x11) and in stage 0 (ready, 0x22) -> rd_data=0x22 and fwd_src=1. The same with stage 0 not ready -> stall=1.
- Issue to r0, then read r0 -> fwd_src=0, rd_data=rf_data, stall=0. A not-ready match with rd_en=0 -> stall=0.
- Assert reset while stall=1 and stall_cnt=7 -> stall=0 and stall_cnt=0 immediately, all fwd_src=0. The hold=1 case separately: entries do not shift over 3 cycles and a res_valid[1] capture is retained.
